// File: rtl/multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multiplier: sequential SIZE/2 x SIZE/2 -> SIZE unsigned shift-add multiply |
// | Optional: MULTIPLIER_EARLY_EXIT_EN ends BUSY once no multiplier bits remain|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multiplier #(
  parameter int SIZE = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SIZE/2-1:0]   input_a_tdata,
  input  logic                input_a_tvalid,
  output logic                input_a_tready,
  input  logic [SIZE/2-1:0]   input_b_tdata,
  input  logic                input_b_tvalid,
  output logic                input_b_tready,
  output logic [SIZE-1:0]     output_tdata,
  output logic                output_tvalid,
  input  logic                output_tready
);

  localparam int              c_w    = SIZE / 2;
  localparam int              c_cw   = $clog2(c_w) + 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_w - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_a_held;
  logic              r_b_held;
  logic [c_w-1:0]    r_a_data;
  logic [c_w-1:0]    r_b_data;
  logic [SIZE-1:0]   r_mcand;
  logic [c_w-1:0]    r_mplier;
  logic [SIZE-1:0]   r_acc;
  logic [c_cw-1:0]   r_count;

  logic              w_a_fire;
  logic              w_b_fire;
  logic [c_w-1:0]    w_a_op;
  logic [c_w-1:0]    w_b_op;
  logic              w_last;

  // Readies come from registered state only; rst gates them low during reset.
  assign input_a_tready = rst && (r_state == S_IDLE) && !r_a_held;
  assign input_b_tready = rst && (r_state == S_IDLE) && !r_b_held;

  assign w_a_fire = input_a_tvalid && input_a_tready;
  assign w_b_fire = input_b_tvalid && input_b_tready;
  assign w_a_op   = w_a_fire ? input_a_tdata : r_a_data;
  assign w_b_op   = w_b_fire ? input_b_tdata : r_b_data;

`ifdef MULTIPLIER_EARLY_EXIT_EN
  assign w_last = (r_count == c_last) || ((r_mplier >> 1) == '0);
`else
  assign w_last = (r_count == c_last);
`endif

  assign output_tvalid = (r_state == S_DONE);
  assign output_tdata  = r_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_a_held <= 1'b0;
      r_b_held <= 1'b0;
      r_a_data <= '0;
      r_b_data <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_a_fire) begin
            r_a_held <= 1'b1;
            r_a_data <= input_a_tdata;
          end
          if (w_b_fire) begin
            r_b_held <= 1'b1;
            r_b_data <= input_b_tdata;
          end
          // Second operand arriving (or both together) starts the multiply.
          if ((r_a_held || w_a_fire) && (r_b_held || w_b_fire)) begin
            r_acc    <= '0;
            r_mcand  <= {{c_w{1'b0}}, w_a_op};
            r_mplier <= w_b_op;
            r_count  <= '0;
            r_a_held <= 1'b0;
            r_b_held <= 1'b0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + c_cw'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (output_tready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multiplier: directed and random checks of multiplier (SIZE=128)         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multiplier;

  localparam int SIZE = 128;
  localparam int W    = SIZE / 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [W-1:0]    a_data = '0;
  logic            a_valid = 1'b0;
  logic            a_ready;
  logic [W-1:0]    b_data = '0;
  logic            b_valid = 1'b0;
  logic            b_ready;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;

  int checks   = 0;
  int failures = 0;

  multiplier #(.SIZE(SIZE)) dut (
    .clk            (clk),
    .rst            (rst),
    .input_a_tdata  (a_data),
    .input_a_tvalid (a_valid),
    .input_a_tready (a_ready),
    .input_b_tdata  (b_data),
    .input_b_tvalid (b_valid),
    .input_b_tready (b_ready),
    .output_tdata   (out_data),
    .output_tvalid  (out_valid),
    .output_tready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W; i += 32) r = (r << 32) | W'($urandom);
    return r;
  endfunction

  function automatic int bitlen(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MULTIPLIER_EARLY_EXIT_EN
    return (bitlen(b) == 0) ? 1 : bitlen(b);
`else
    return W;
`endif
  endfunction

  function automatic logic [SIZE-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [SIZE-1:0] x = SIZE'(a);
    logic [SIZE-1:0] y = SIZE'(b);
    return x * y;
  endfunction

  // Offer a now and b after b_gap cycles, then stall the result for hold cycles.
  task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [SIZE-1:0] exp_p, input int b_gap, input int hold);
    bit a_done = 1'b0;
    bit b_done = 1'b0;
    int cyc = 0;
    int lat = 0;
    @(posedge clk); #1;
    out_ready = (hold == 0);
    a_data  = a;
    a_valid = 1'b1;
    while (!(a_done && b_done) && cyc < 100) begin
      if (cyc == b_gap) begin
        b_data  = b;
        b_valid = 1'b1;
      end
      @(negedge clk);
      if (a_done) check({tag, ":a_ready_held_low"}, SIZE'(a_ready), 0);
      if (a_valid && a_ready) a_done = 1'b1;
      if (b_valid && b_ready) b_done = 1'b1;
      @(posedge clk); #1;
      if (a_done) a_valid = 1'b0;
      if (b_done) b_valid = 1'b0;
      cyc++;
    end
    check({tag, ":accept"}, SIZE'(a_done && b_done), 1);
    while (lat < 2 * W + 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check({tag, ":valid"}, SIZE'(out_valid), 1);
    check({tag, ":latency"}, SIZE'(lat), SIZE'(exp_latency(b)));
    check({tag, ":product"}, out_data, exp_p);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, ":stall_valid"}, SIZE'(out_valid), 1);
      check({tag, ":stall_data"}, out_data, exp_p);
      check({tag, ":stall_readies"}, SIZE'({a_ready, b_ready}), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ":valid_drop"}, SIZE'(out_valid), 0);
    check({tag, ":readies_back"}, SIZE'({a_ready, b_ready}), 3);
  endtask

  initial begin
    logic [W-1:0]    ra, rb;
    logic [W-1:0]    qa [2];
    logic [W-1:0]    qb [2];
    int              rise [2];
    int              n_out, idx, cyc;
    bit              prev, fire;

    #1 rst = 1'b0;
    #2;
    check("reset_valid", SIZE'(out_valid), 0);
    check("reset_data", out_data, 0);
    check("reset_readies", SIZE'({a_ready, b_ready}), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("release_readies", SIZE'({a_ready, b_ready}), 3);

    ra = '1;
    mul("all_ones", ra, ra, 128'hFFFFFFFFFFFFFFFE0000000000000001, 0, 0);
    mul("a7_b3_gap", 7, 3, 21, 5, 0);
    mul("b_zero", 12345, 0, 0, 0, 0);
    mul("stall", 64'h10000, 64'h10000, 128'h1_0000_0000, 0, 10);

    for (int k = 0; k < 6; k++) begin
      ra = rand_w();
      rb = rand_w() >> $urandom_range(0, W - 1);
      mul("random", ra, rb, model(ra, rb), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // Back-to-back products; top multiplier bit set so latency is W in either build.
    for (int k = 0; k < 2; k++) begin
      qa[k] = rand_w();
      qb[k] = rand_w() | {1'b1, {(W-1){1'b0}}};
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idx = 0; n_out = 0; cyc = 0; prev = 1'b0;
    a_data = qa[0]; b_data = qb[0]; a_valid = 1'b1; b_valid = 1'b1;
    rise[0] = 0; rise[1] = 0;
    while (n_out < 2 && cyc < 4 * W) begin
      @(negedge clk);
      if (out_valid && !prev) begin
        rise[n_out] = cyc;
        check("b2b_product", out_data, model(qa[n_out], qb[n_out]));
        n_out++;
      end
      prev = out_valid;
      fire = a_valid && a_ready && b_ready;
      @(posedge clk); #1;
      cyc++;
      if (fire) begin
        idx++;
        if (idx < 2) begin
          a_data = qa[idx];
          b_data = qb[idx];
        end else begin
          a_valid = 1'b0;
          b_valid = 1'b0;
        end
      end
    end
    check("b2b_count", SIZE'(n_out), 2);
    check("b2b_spacing", SIZE'(rise[1] - rise[0]), SIZE'(W + 2));
    a_valid = 1'b0;
    b_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Abort a multiply mid-flight with reset.
    @(posedge clk); #1;
    a_data = '1; b_data = '1; a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    check("abort_accept", SIZE'({a_ready, b_ready}), 3);
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("abort_valid", SIZE'(out_valid), 0);
    check("abort_data", out_data, 0);
    check("abort_readies", SIZE'({a_ready, b_ready}), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_release_valid", SIZE'(out_valid), 0);
    check("abort_release_readies", SIZE'({a_ready, b_ready}), 3);
    mul("after_abort", 5, 6, 30, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
